// File: rtl/calu_pkg.sv
// Shared CALU definitions: opcode encodings, status-flag bit positions and a
// helper that spots a divide-by-zero result in a flag vector.
package calu_pkg;

  localparam int OPC_W  = 4;
  localparam int FLAG_W = 12;

  localparam logic [OPC_W-1:0] CADD  = 4'h0;
  localparam logic [OPC_W-1:0] CSUB  = 4'h1;
  localparam logic [OPC_W-1:0] CMUL  = 4'h2;
  localparam logic [OPC_W-1:0] CDIV  = 4'h3;
  localparam logic [OPC_W-1:0] CMAG  = 4'h4;
  localparam logic [OPC_W-1:0] CAND  = 4'h5;
  localparam logic [OPC_W-1:0] COR   = 4'h6;
  localparam logic [OPC_W-1:0] CNOT  = 4'h7;
  localparam logic [OPC_W-1:0] CXOR  = 4'h8;
  localparam logic [OPC_W-1:0] CXNOR = 4'h9;
  localparam logic [OPC_W-1:0] CNAND = 4'hA;
  localparam logic [OPC_W-1:0] CNOR  = 4'hB;
  localparam logic [OPC_W-1:0] CINC  = 4'hC;
  localparam logic [OPC_W-1:0] CDEC  = 4'hD;
  localparam logic [OPC_W-1:0] CSWAP = 4'hE;
  localparam logic [OPC_W-1:0] CCONJ = 4'hF;

  localparam int FLG_CR   = 11;
  localparam int FLG_CI   = 10;
  localparam int FLG_DVFR = 9;
  localparam int FLG_DVFI = 8;
  localparam int FLG_ZER  = 7;
  localparam int FLG_ZEI  = 6;
  localparam int FLG_ZR   = 5;
  localparam int FLG_ZI   = 4;
  localparam int FLG_OR   = 3;
  localparam int FLG_OI   = 2;
  localparam int FLG_NR   = 1;
  localparam int FLG_NI   = 0;

  function automatic logic dvz_hit(input logic [FLAG_W-1:0] flags);
    return flags[FLG_ZER] | flags[FLG_ZEI];
  endfunction

endpackage

// File: rtl/calu_status_acc.sv
// Status accumulator: sticky OR of pushed flags and a saturating count of
// divide-by-zero pushes. A clear on the same edge as a push keeps the push.
module calu_status_acc
  import calu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              clr_i,
  input  logic [FLAG_W-1:0] flags_i,
  output logic [FLAG_W-1:0] sticky_o,
  output logic [CNT_W-1:0]  dvz_cnt_o
);

  logic [FLAG_W-1:0] sticky_q, sticky_d, sticky_base;
  logic [CNT_W-1:0]  dvz_q, dvz_d, dvz_base;

  always_comb begin
    sticky_base = clr_i ? '0 : sticky_q;
    dvz_base    = clr_i ? '0 : dvz_q;
    sticky_d    = sticky_base;
    dvz_d       = dvz_base;
    if (push_i) begin
      sticky_d = sticky_base | flags_i;
      if (dvz_hit(flags_i) && (dvz_base != {CNT_W{1'b1}}))
        dvz_d = dvz_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
      dvz_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      dvz_q    <= dvz_d;
    end
  end

  assign sticky_o  = sticky_q;
  assign dvz_cnt_o = dvz_q;

endmodule

// File: rtl/calu_result_fifo.sv
// First-word-fall-through result FIFO behind the CALU. Occupancy is tracked
// by an explicit count so full/empty never depend on pointer equality.
module calu_result_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int FLAG_W = calu_pkg::FLAG_W,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_opcode,
  input  logic [DATA_W-1:0]          in_z,
  input  logic [FLAG_W-1:0]          in_flags,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_opcode,
  output logic [DATA_W-1:0]          out_z,
  output logic [FLAG_W-1:0]          out_flags,
  output logic [$clog2(DEPTH):0]     count,
  output logic [FLAG_W-1:0]          sticky_flags,
  input  logic                       sticky_clr,
  output logic [CNT_W-1:0]           dvz_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_FW = PTR_W + 1;

  logic [3:0]        opc_q  [DEPTH];
  logic [DATA_W-1:0] z_q    [DEPTH];
  logic [FLAG_W-1:0] flg_q  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic              full, empty, push, pop;

  assign full  = (count_q == CNT_FW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_valid && !full;
  assign pop   = out_ready && !empty;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)
      count_d = count_q + CNT_FW'(1);
    else if (pop && !push)
      count_d = count_q - CNT_FW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        opc_q[i] <= '0;
        z_q[i]   <= '0;
        flg_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        opc_q[wr_ptr_q] <= in_opcode;
        z_q[wr_ptr_q]   <= in_z;
        flg_q[wr_ptr_q] <= in_flags;
      end
    end
  end

  // Head is masked to zero while empty so stale entries never leak out.
  assign in_ready   = !full;
  assign out_valid  = !empty;
  assign out_opcode = empty ? '0 : opc_q[rd_ptr_q];
  assign out_z      = empty ? '0 : z_q[rd_ptr_q];
  assign out_flags  = empty ? '0 : flg_q[rd_ptr_q];
  assign count      = count_q;

  calu_status_acc #(
    .CNT_W (CNT_W)
  ) u_status_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .clr_i     (sticky_clr),
    .flags_i   (in_flags),
    .sticky_o  (sticky_flags),
    .dvz_cnt_o (dvz_count)
  );

endmodule

// File: tb/tb_calu_result_fifo.sv
// Randomized and directed checks of calu_result_fifo against a queue-based
// reference model.
module tb_calu_result_fifo;
  import calu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_opcode;
  logic [31:0] in_z;
  logic [11:0] in_flags;
  logic        out_valid, out_ready;
  logic [3:0]  out_opcode;
  logic [31:0] out_z;
  logic [11:0] out_flags;
  logic [2:0]  count;
  logic [11:0] sticky_flags;
  logic        sticky_clr;
  logic [7:0]  dvz_count;

  calu_result_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_z         (in_z),
    .in_flags     (in_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_z        (out_z),
    .out_flags    (out_flags),
    .count        (count),
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr),
    .dvz_count    (dvz_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  opc;
    logic [31:0] z;
    logic [11:0] f;
  } ent_t;

  ent_t        mq[$];
  logic [11:0] m_sticky;
  int          m_dvz;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    ent_t h;
    h.opc = '0; h.z = '0; h.f = '0;
    if (mq.size() > 0) h = mq[0];
    chk("in_ready",  in_ready,  mq.size() < DEPTH);
    chk("out_valid", out_valid, mq.size() > 0);
    chk("count",     count,     mq.size());
    chk("out_opcode", out_opcode, h.opc);
    chk("out_z",      out_z,      h.z);
    chk("out_flags",  out_flags,  h.f);
    chk("sticky",     sticky_flags, m_sticky);
    chk("dvz",        dvz_count,    m_dvz);
  endtask

  // Drives one cycle (called just after a falling edge), checks pre-edge
  // outputs, then advances the model by the rules of the handshake.
  task automatic step(input logic v, input logic [3:0] opc, input logic [31:0] z,
                      input logic [11:0] f, input logic rdy, input logic clr);
    bit   do_push, do_pop;
    ent_t e;
    in_valid = v; in_opcode = opc; in_z = z; in_flags = f;
    out_ready = rdy; sticky_clr = clr;
    #1;
    check_outputs();
    do_push = v && (mq.size() < DEPTH);
    do_pop  = rdy && (mq.size() > 0);
    @(posedge clk);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      e.opc = opc; e.z = z; e.f = f;
      mq.push_back(e);
    end
    if (clr) begin
      m_sticky = '0;
      m_dvz    = 0;
    end
    if (do_push) begin
      m_sticky = m_sticky | f;
      if ((f[FLG_ZER] || f[FLG_ZEI]) && m_dvz < 255) m_dvz++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 32'h0, 12'h0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_sticky = '0;
    m_dvz    = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_opcode = '0; in_z = '0; in_flags = '0;
    out_ready = 1'b0; sticky_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Single push then pop
    step(1'b1, CADD, 32'h0003_0003, 12'h000, 1'b0, 1'b0);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_z", out_z, 32'h0003_0003);
    step(1'b0, 4'h0, 32'h0, 12'h0, 1'b1, 1'b0);
    idle();

    // Fill past full, then drain
    for (int i = 1; i <= 5; i++) step(1'b1, CSUB, 32'(i), 12'h000, 1'b0, 1'b0);
    chk("t2_ready", in_ready, 1'b0);
    chk("t2_count", count, 3'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_order", out_z, 32'(i));
      step(1'b0, 4'h0, 32'h0, 12'h0, 1'b1, 1'b0);
    end
    chk("t2_empty", out_valid, 1'b0);

    // Hold two entries and push+pop every cycle across pointer wrap
    step(1'b1, CMUL, 32'h100, 12'h000, 1'b0, 1'b0);
    step(1'b1, CMUL, 32'h101, 12'h000, 1'b0, 1'b0);
    for (int i = 2; i < 12; i++) begin
      chk("t3_order", out_z, 32'h100 + 32'(i - 2));
      step(1'b1, CMUL, 32'h100 + 32'(i), 12'h000, 1'b1, 1'b0);
    end
    chk("t3_count", count, 3'd2);
    step(1'b0, 4'h0, 32'h0, 12'h0, 1'b1, 1'b1);
    step(1'b0, 4'h0, 32'h0, 12'h0, 1'b1, 1'b0);

    // Sticky flags and divide-by-zero count
    step(1'b1, CDIV, 32'h7, 12'h0C0, 1'b1, 1'b0);
    step(1'b1, CADD, 32'h8, 12'h002, 1'b1, 1'b0);
    chk("t4_sticky", sticky_flags, 12'h0C2);
    chk("t4_dvz", dvz_count, 8'd1);
    step(1'b1, CDIV, 32'h9, 12'h040, 1'b1, 1'b1);
    chk("t4_clr_sticky", sticky_flags, 12'h040);
    chk("t4_clr_dvz", dvz_count, 8'd1);
    step(1'b0, 4'h0, 32'h0, 12'h0, 1'b1, 1'b0);

    // Saturation after 300 divide-by-zero pushes
    for (int i = 0; i < 300; i++)
      step(1'b1, CDIV, $urandom, 12'($urandom) | 12'h080, 1'b1, 1'b0);
    chk("t5_sat", dvz_count, 8'd255);
    step(1'b0, 4'h0, 32'h0, 12'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges with three entries stored
    for (int i = 0; i < 3; i++) step(1'b1, CXOR, 32'hA0 + 32'(i), 12'h00F, 1'b0, 1'b0);
    chk("t6_pre", count, 3'd3);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_count", count, 3'd0);
    chk("t6_ready", in_ready, 1'b1);
    chk("t6_sticky", sticky_flags, 12'h000);
    chk("t6_z", out_z, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) < 60, 4'($urandom), $urandom, 12'($urandom),
           $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 5);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/calu_result_fifo.md
Name: calu_result_fifo

Overview:
- Downstream stage of the complex ALU (CALU).
- Captures each CALU result (32-bit Zout = {real[15:0], imag[15:0]}) together with its opcode tag and its 12 status flags into a small FIFO.
- Presents results to the writeback/consumer side through a valid/ready handshake.
- Keeps a sticky OR of all captured flags, plus a saturating count of divide-by-zero results, for software/status polling.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of 2, ≥2.
- DATA_W, 32, width of the complex result word.
- FLAG_W, 12, width of the status-flag vector.
- CNT_W, 8, width of the divide-by-zero event counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a CALU result is offered.
- in_ready  output  1  FIFO can accept; equals !full.
- in_opcode  input  4  opcode that produced the result.
- in_z  input  DATA_W  CALU Zout.
- in_flags  input  FLAG_W  {CR,CI,DVFR,DVFI,ZER,ZEI,ZR,ZI,OR,OI,NR,NI}, bit 11 = CR, bit 0 = NI.
- out_valid  output  1  head entry is valid; equals !empty.
- out_ready  input  1  consumer accepts the head entry.
- out_opcode  output  4  head opcode.
- out_z  output  DATA_W  head result.
- out_flags  output  FLAG_W  head flags.
- count  output  $clog2(DEPTH)+1  current occupancy.
- sticky_flags  output  FLAG_W  OR of flags of all pushes since last clear.
- sticky_clr  input  1  synchronous clear of sticky_flags and dvz_count.
- dvz_count  output  CNT_W  number of pushes with ZER|ZEI set; saturating.

Behaviour:
- Reset (async, rst_n=0):
  - Pointers = 0, count = 0, sticky_flags = 0, dvz_count = 0, storage cleared.
  - Outputs during and after reset: out_valid=0, out_z/out_opcode/out_flags=0, in_ready=1.
- Push: occurs on an edge with in_valid && in_ready. Stores {in_opcode, in_z, in_flags} at the write pointer; wr_ptr increments modulo DEPTH.
- Pop: occurs on an edge with out_valid && out_ready. rd_ptr increments modulo DEPTH.
- Output data: out_* are driven combinationally from the storage entry at rd_ptr (first-word-fall-through). When empty, out_* are 0.
- Latency: an entry pushed at edge N is visible on out_* with out_valid=1 after edge N. Empty-FIFO bypass in the same cycle is not permitted.
- count:
  - +1 on push only, −1 on pop only.
  - Unchanged on a simultaneous push and pop.
  - Never exceeds DEPTH and never underflows.
- Full (count==DEPTH): in_ready=0; in_valid is ignored, with no state change and no data loss of stored entries. A pop in the same cycle frees a slot only from the next cycle onward (in_ready is not combinationally dependent on out_ready).
- Empty (count==0): out_valid=0; out_ready is ignored.
- Simultaneous push and pop with 0<count<DEPTH: both happen, and count is unchanged.
- Pointer wrap: wr_ptr and rd_ptr wrap DEPTH-1 → 0. Full vs. empty is resolved by count, not by pointer equality.
- Sticky flags:
  - On a push edge: sticky_flags <= sticky_flags | in_flags.
  - On sticky_clr: sticky_flags <= 0.
  - sticky_clr together with a push on the same edge: sticky_flags <= in_flags (clear of old state, new push still recorded).
- dvz_count:
  - Increments on a push with in_flags[7]|in_flags[6] (ZER|ZEI).
  - Saturates at 2^CNT_W−1.
  - Clear/push priority is the same as sticky: clear+dvz push → 1.
- Mid-operation reset: all entries are discarded immediately, with no handshake.
- Internal state machine: none beyond the pointers and count. No X may propagate to outputs after reset.

Decomposition:
- Shared package calu_pkg:
  - Opcode localparams: CADD=4'h0, CSUB=1, CMUL=2, CDIV=3, CMAG=4, CAND=5, COR=6, CNOT=7, CXOR=8, CXNOR=9, CNAND=A, CNOR=B, CINC=C, CDEC=D, CSWAP=E, CCONJ=F.
  - Flag bit-index localparams: FLG_CR=11 … FLG_NI=0.
  - FLAG_W=12.
- One sub-module, calu_status_acc, holds the sticky_flags/dvz_count logic. The FIFO storage and pointers stay in the top.

Test Plan:
1. Single push/pop: reset, then push in_z=32'h0003_0003, opcode=CADD, flags=0 → next cycle out_valid=1, out_z=32'h0003_0003, count=1. Pop with out_ready=1 → out_valid=0, count=0.
2. Fill/full: 5 consecutive pushes with out_ready=0 and in_z=1..5 → in_ready=0 after the 4th, count=4, entry 5 is not stored. Drain → out_z order 1,2,3,4, then out_valid=0.
3. Wrap + simultaneous push/pop: hold count=2 and push+pop every cycle for 10 cycles → count stays 2, output order matches input order across pointer wrap.
4. Sticky/DVZ: push flags 12'h0C0 (ZER|ZEI, CDIV) then 12'h002 (NR) → sticky_flags=12'h0C2, dvz_count=1. sticky_clr together with a push of 12'h040 → sticky_flags=12'h040, dvz_count=1.
5. Saturation: 300 pushes with ZER set (pop every cycle) → dvz_count=255.
6. Async reset: with 3 entries stored, assert rst_n=0 between edges → out_valid=0, count=0, in_ready=1, sticky_flags=0 immediately, without waiting for a clock edge.
